sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 selects round-robin arbitration; 0 gives port 0 fixed priority.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for controller completion before the block aborts the wait.
REQ-003 Port clk, input, 1: the single clock; all logic is on posedge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports cN_addr / cN_data / cN_byte_en (N=0,1), input, 25/16/2: client word address [25:1], write data, and byte enables.
REQ-006 Ports cN_wr_req / cN_rd_req, input, 1: single-cycle client request strobes.
REQ-007 Port cN_ready, output, 1: client may issue a request this cycle.
REQ-008 Ports cN_q / cN_q_valid, output, 32/1: read data, with a 1-cycle valid pulse.
REQ-009 Port cN_timeout, output, 1: 1-cycle pulse when the client's request is aborted.
REQ-010 Ports p0_addr / p0_data / p0_byte_en / p0_wr_req / p0_rd_req, output, 25/16/2/1/1: controller command port, registered.
REQ-011 Ports p0_q (32), p0_ready (1) and init_complete (1), input: controller read data, idle indication, and initialisation done.

Function
REQ-012 Each client has a pending latch. A request with cN_ready=1 captures addr, data, byte_en and op. If wr and rd are asserted together, the write is captured and the read is dropped.
REQ-013 cN_ready = ~pendingN. A request while cN_ready=0 is ignored.
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE -> ISSUE when init_complete=1, p0_ready=1 and any pending=1. The grant is latched on that transition.
REQ-016 Arbitration when both clients are pending:
- ROUND_ROBIN=1: the port not granted last wins; port 0 wins after reset.
- ROUND_ROBIN=0: port 0 always wins.
REQ-017 ISSUE lasts exactly 1 cycle. During it, p0_wr_req or p0_rd_req=1 together with the granted client's addr, data and byte_en. Next state is WAIT_BUSY.
REQ-018 p0_*_req are 0 in every cycle except ISSUE. Command data outputs hold their last value.
REQ-019 WAIT_BUSY -> WAIT_DONE on the first cycle with p0_ready=0.
REQ-020 WAIT_DONE -> IDLE on the first cycle with p0_ready=1 (completion). On that same edge:
- the granted pending latch clears;
- for a read, cN_q <= p0_q and cN_q_valid pulses for 1 cycle.
REQ-021 A timeout counter resets on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES: return to IDLE, clear the granted pending latch, and pulse cN_timeout. No q_valid is generated.
REQ-022 A client may request on the cycle after its q_valid or timeout pulse; the issue then follows no earlier than the next IDLE evaluation.
REQ-023 The non-granted client's pending latch and captured fields are unaffected by a grant.
REQ-024 init_complete falling to 0 in any state returns the FSM to IDLE. Pending latches are kept and no pulse is emitted.

Reset
REQ-025 When reset_n=0, asynchronously:
- state=IDLE;
- pending=0 (so cN_ready=1 once reset_n=1);
- p0_*_req=0, p0_addr/data/byte_en=0;
- cN_q=0, cN_q_valid=0, cN_timeout=0;
- last grant = port 1 (so port 0 wins first);
- timeout counter=0.
REQ-026 Reset mid-operation drops all requests without pulses.

Structure
REQ-027 Package sdram_pkg holds:
- the state enum;
- op typedef (OP_READ, OP_WRITE);
- port-id typedef;
- address, data and q width constants shared with the controller.
REQ-028 One sub-module, sdram_client_latch, instantiated once per client. It holds the pending flag and captured fields, and outputs cN_ready.
REQ-029 The arbiter FSM, timeout counter and output mux live in the top module.

Verification
REQ-030 Single write: c0 writes addr 0x0000123, data 0xBEEF, be 2'b11.
- Exactly one p0_wr_req pulse with the same values.
- c0_ready returns to 1 on the edge where p0_ready returns high.
REQ-031 Read: c1 reads 0x1000000; the model returns p0_q=0xCAFEF00D.
- c1_q=0xCAFEF00D with a single c1_q_valid pulse.
REQ-032 Contention, ROUND_ROBIN=1: both clients request in the same cycle twice in a row.
- Issue order is c0, c1, c0, c1.
- With ROUND_ROBIN=0 the order is c0, c0 before any c1.
REQ-033 Timeout, TIMEOUT_CYCLES=8: the model holds p0_ready=0 indefinitely after issue.
- c0_timeout pulses 8 cycles after WAIT_BUSY entry.
- No q_valid; c0_ready returns to 1.
REQ-034 Gating and boundaries:
- init_complete=0 with a pending request: no p0 request until init_complete=1.
- Simultaneous c0 wr+rd: only the write is issued.
- reset_n asserted during WAIT_DONE: all outputs are at reset values immediately.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM arbiter and the controller it drives.
package sdram_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;
    localparam int Q_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

endpackage

// File: rtl/sdram_client_latch.sv
// Per-client request holder: captures one command and keeps it until the arbiter clears it.
module sdram_client_latch
    import sdram_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [BE_W-1:0]   byte_en,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              clear,
    output logic              ready,
    output logic              pending,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [DATA_W-1:0] lat_data,
    output logic [BE_W-1:0]   lat_byte_en,
    output op_e               lat_op
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BE_W-1:0]   be_q, be_d;
    op_e               op_q, op_d;

    // Capture when free (write beats read), release on clear.
    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        op_d      = op_q;
        if (!pending_q) begin
            if (wr_req) begin
                pending_d = 1'b1;
                addr_d    = addr;
                data_d    = data;
                be_d      = byte_en;
                op_d      = OP_WRITE;
            end else if (rd_req) begin
                pending_d = 1'b1;
                addr_d    = addr;
                data_d    = data;
                be_d      = byte_en;
                op_d      = OP_READ;
            end else begin
                pending_d = 1'b0;
            end
        end else if (clear) begin
            pending_d = 1'b0;
        end else begin
            pending_d = 1'b1;
        end
    end

    // Latch state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= {DATA_W{1'b0}};
            be_q      <= {BE_W{1'b0}};
            op_q      <= OP_READ;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            op_q      <= op_d;
        end
    end

    assign ready       = ~pending_q;
    assign pending     = pending_q;
    assign lat_addr    = addr_q;
    assign lat_data    = data_q;
    assign lat_byte_en = be_q;
    assign lat_op      = op_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of a single SDRAM controller command port,
// with round-robin or fixed priority and a bounded wait for completion.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_data,
    input  logic [BE_W-1:0]   c0_byte_en,
    input  logic              c0_wr_req,
    input  logic              c0_rd_req,
    output logic              c0_ready,
    output logic [Q_W-1:0]    c0_q,
    output logic              c0_q_valid,
    output logic              c0_timeout,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_data,
    input  logic [BE_W-1:0]   c1_byte_en,
    input  logic              c1_wr_req,
    input  logic              c1_rd_req,
    output logic              c1_ready,
    output logic [Q_W-1:0]    c1_q,
    output logic              c1_q_valid,
    output logic              c1_timeout,
    output logic [ADDR_W-1:0] p0_addr,
    output logic [DATA_W-1:0] p0_data,
    output logic [BE_W-1:0]   p0_byte_en,
    output logic              p0_wr_req,
    output logic              p0_rd_req,
    input  logic [Q_W-1:0]    p0_q,
    input  logic              p0_ready,
    input  logic              init_complete
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic              pend0_s, pend1_s, clr0_s, clr1_s;
    logic [ADDR_W-1:0] l0_addr_s, l1_addr_s, sel_addr_s;
    logic [DATA_W-1:0] l0_data_s, l1_data_s, sel_data_s;
    logic [BE_W-1:0]   l0_be_s, l1_be_s, sel_be_s;
    op_e               l0_op_s, l1_op_s, sel_op_s, gnt_op_s;
    port_e             sel_port_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    state_e            state_q, state_d;
    port_e             grant_q, grant_d, last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] p0_addr_q, p0_addr_d;
    logic [DATA_W-1:0] p0_data_q, p0_data_d;
    logic [BE_W-1:0]   p0_be_q, p0_be_d;
    logic              p0_wr_q, p0_wr_d, p0_rd_q, p0_rd_d;
    logic [Q_W-1:0]    c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;
    logic              c0_qv_q, c0_qv_d, c1_qv_q, c1_qv_d;
    logic              c0_to_q, c0_to_d, c1_to_q, c1_to_d;

    sdram_client_latch u_latch0 (
        .clk(clk), .reset_n(reset_n), .addr(c0_addr), .data(c0_data), .byte_en(c0_byte_en),
        .wr_req(c0_wr_req), .rd_req(c0_rd_req), .clear(clr0_s), .ready(c0_ready),
        .pending(pend0_s), .lat_addr(l0_addr_s), .lat_data(l0_data_s),
        .lat_byte_en(l0_be_s), .lat_op(l0_op_s)
    );

    sdram_client_latch u_latch1 (
        .clk(clk), .reset_n(reset_n), .addr(c1_addr), .data(c1_data), .byte_en(c1_byte_en),
        .wr_req(c1_wr_req), .rd_req(c1_rd_req), .clear(clr1_s), .ready(c1_ready),
        .pending(pend1_s), .lat_addr(l1_addr_s), .lat_data(l1_data_s),
        .lat_byte_en(l1_be_s), .lat_op(l1_op_s)
    );

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Winner selection; on a tie round-robin favours the port not served last.
    always_comb begin
        if (pend0_s && pend1_s) begin
            sel_port_s = ((ROUND_ROBIN != 0) && (last_grant_q == PORT_0)) ? PORT_1 : PORT_0;
        end else if (pend1_s) begin
            sel_port_s = PORT_1;
        end else begin
            sel_port_s = PORT_0;
        end
        sel_addr_s = (sel_port_s == PORT_0) ? l0_addr_s : l1_addr_s;
        sel_data_s = (sel_port_s == PORT_0) ? l0_data_s : l1_data_s;
        sel_be_s   = (sel_port_s == PORT_0) ? l0_be_s   : l1_be_s;
        sel_op_s   = (sel_port_s == PORT_0) ? l0_op_s   : l1_op_s;
        gnt_op_s   = (grant_q == PORT_0)    ? l0_op_s   : l1_op_s;
    end

    // Next-state, command and client-response logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        p0_addr_d    = p0_addr_q;
        p0_data_d    = p0_data_q;
        p0_be_d      = p0_be_q;
        p0_wr_d      = 1'b0;
        p0_rd_d      = 1'b0;
        c0_rdata_d   = c0_rdata_q;
        c1_rdata_d   = c1_rdata_q;
        c0_qv_d      = 1'b0;
        c1_qv_d      = 1'b0;
        c0_to_d      = 1'b0;
        c1_to_d      = 1'b0;
        clr0_s       = 1'b0;
        clr1_s       = 1'b0;
        if (!init_complete) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (p0_ready && (pend0_s || pend1_s)) begin
                        state_d      = ST_ISSUE;
                        grant_d      = sel_port_s;
                        last_grant_d = sel_port_s;
                        p0_addr_d    = sel_addr_s;
                        p0_data_d    = sel_data_s;
                        p0_be_d      = sel_be_s;
                        p0_wr_d      = (sel_op_s == OP_WRITE);
                        p0_rd_d      = (sel_op_s == OP_READ);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT_BUSY;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    cnt_d = cnt_inc_s;
                    // Completion wins over a timeout landing on the same cycle.
                    if ((state_q == ST_WAIT_DONE) && p0_ready) begin
                        state_d = ST_IDLE;
                        clr0_s  = (grant_q == PORT_0);
                        clr1_s  = (grant_q == PORT_1);
                        if (gnt_op_s == OP_READ) begin
                            if (grant_q == PORT_0) begin
                                c0_rdata_d = p0_q;
                                c0_qv_d    = 1'b1;
                            end else begin
                                c1_rdata_d = p0_q;
                                c1_qv_d    = 1'b1;
                            end
                        end else begin
                            c0_qv_d = 1'b0;
                        end
                    end else if (cnt_inc_s == CNT_LIMIT) begin
                        state_d = ST_IDLE;
                        clr0_s  = (grant_q == PORT_0);
                        clr1_s  = (grant_q == PORT_1);
                        c0_to_d = (grant_q == PORT_0);
                        c1_to_d = (grant_q == PORT_1);
                    end else if ((state_q == ST_WAIT_BUSY) && !p0_ready) begin
                        state_d = ST_WAIT_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= PORT_0;
            last_grant_q <= PORT_1;
            cnt_q        <= {CNT_W{1'b0}};
            p0_addr_q    <= {ADDR_W{1'b0}};
            p0_data_q    <= {DATA_W{1'b0}};
            p0_be_q      <= {BE_W{1'b0}};
            p0_wr_q      <= 1'b0;
            p0_rd_q      <= 1'b0;
            c0_rdata_q   <= {Q_W{1'b0}};
            c1_rdata_q   <= {Q_W{1'b0}};
            c0_qv_q      <= 1'b0;
            c1_qv_q      <= 1'b0;
            c0_to_q      <= 1'b0;
            c1_to_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            p0_addr_q    <= p0_addr_d;
            p0_data_q    <= p0_data_d;
            p0_be_q      <= p0_be_d;
            p0_wr_q      <= p0_wr_d;
            p0_rd_q      <= p0_rd_d;
            c0_rdata_q   <= c0_rdata_d;
            c1_rdata_q   <= c1_rdata_d;
            c0_qv_q      <= c0_qv_d;
            c1_qv_q      <= c1_qv_d;
            c0_to_q      <= c0_to_d;
            c1_to_q      <= c1_to_d;
        end
    end

    assign p0_addr    = p0_addr_q;
    assign p0_data    = p0_data_q;
    assign p0_byte_en = p0_be_q;
    assign p0_wr_req  = p0_wr_q;
    assign p0_rd_req  = p0_rd_q;
    assign c0_q       = c0_rdata_q;
    assign c1_q       = c1_rdata_q;
    assign c0_q_valid = c0_qv_q;
    assign c1_q_valid = c1_qv_q;
    assign c0_timeout = c0_to_q;
    assign c1_timeout = c1_to_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority; both use an 8-cycle timeout.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_c = 1'b1;
    logic        hang = 1'b0;
    logic [31:0] model_q = 32'h0000_0000;
    logic [24:0] c0_addr = 25'd0, c1_addr = 25'd0;
    logic [15:0] c0_data = 16'd0, c1_data = 16'd0;
    logic [1:0]  c0_be = 2'd0, c1_be = 2'd0;
    logic        c0_wr = 1'b0, c0_rd = 1'b0, c1_wr = 1'b0, c1_rd = 1'b0;

    logic        c0_ready_a [2], c1_ready_a [2], c0_qv_a [2], c1_qv_a [2], c0_to_a [2], c1_to_a [2];
    logic [31:0] c0_q_a [2], c1_q_a [2];
    logic [24:0] p0_addr_a [2];
    logic [15:0] p0_data_a [2];
    logic [1:0]  p0_be_a [2];
    logic        p0_wr_a [2], p0_rd_a [2];
    logic [1:0]  p0_ready_v;

    int          busy_cnt [2];
    int          n_iss [2];
    logic [24:0] ord_addr [2][8];
    logic [15:0] ord_data [2][8];
    logic [1:0]  ord_be [2][8];
    logic        ord_wr [2][8];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_byte_en(c0_be), .c0_wr_req(c0_wr), .c0_rd_req(c0_rd),
        .c0_ready(c0_ready_a[0]), .c0_q(c0_q_a[0]), .c0_q_valid(c0_qv_a[0]), .c0_timeout(c0_to_a[0]),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_byte_en(c1_be), .c1_wr_req(c1_wr), .c1_rd_req(c1_rd),
        .c1_ready(c1_ready_a[0]), .c1_q(c1_q_a[0]), .c1_q_valid(c1_qv_a[0]), .c1_timeout(c1_to_a[0]),
        .p0_addr(p0_addr_a[0]), .p0_data(p0_data_a[0]), .p0_byte_en(p0_be_a[0]),
        .p0_wr_req(p0_wr_a[0]), .p0_rd_req(p0_rd_a[0]),
        .p0_q(model_q), .p0_ready(p0_ready_v[0]), .init_complete(init_c)
    );

    sdram_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_byte_en(c0_be), .c0_wr_req(c0_wr), .c0_rd_req(c0_rd),
        .c0_ready(c0_ready_a[1]), .c0_q(c0_q_a[1]), .c0_q_valid(c0_qv_a[1]), .c0_timeout(c0_to_a[1]),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_byte_en(c1_be), .c1_wr_req(c1_wr), .c1_rd_req(c1_rd),
        .c1_ready(c1_ready_a[1]), .c1_q(c1_q_a[1]), .c1_q_valid(c1_qv_a[1]), .c1_timeout(c1_to_a[1]),
        .p0_addr(p0_addr_a[1]), .p0_data(p0_data_a[1]), .p0_byte_en(p0_be_a[1]),
        .p0_wr_req(p0_wr_a[1]), .p0_rd_req(p0_rd_a[1]),
        .p0_q(model_q), .p0_ready(p0_ready_v[1]), .init_complete(init_c)
    );

    // Controller model: logs each command, then goes busy for 3 cycles (or forever when hung).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                p0_ready_v[i] <= 1'b1;
                busy_cnt[i] = 0;
                n_iss[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (p0_wr_a[i] || p0_rd_a[i]) begin
                    if (n_iss[i] < 8) begin
                        ord_addr[i][n_iss[i]] = p0_addr_a[i];
                        ord_data[i][n_iss[i]] = p0_data_a[i];
                        ord_be[i][n_iss[i]]   = p0_be_a[i];
                        ord_wr[i][n_iss[i]]   = p0_wr_a[i];
                    end
                    n_iss[i] = n_iss[i] + 1;
                    p0_ready_v[i] <= 1'b0;
                    busy_cnt[i] = hang ? 0 : 3;
                end else if (busy_cnt[i] > 0) begin
                    busy_cnt[i] = busy_cnt[i] - 1;
                    if (busy_cnt[i] == 0) p0_ready_v[i] <= 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        init_c = 1'b1;
        hang = 1'b0;
        c0_wr = 1'b0; c0_rd = 1'b0; c1_wr = 1'b0; c1_rd = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic drive_req(input int cl, input logic wr, input logic rd,
                             input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        if (cl == 0) begin
            c0_addr = a; c0_data = d; c0_be = be; c0_wr = wr; c0_rd = rd;
        end else begin
            c1_addr = a; c1_data = d; c1_be = be; c1_wr = wr; c1_rd = rd;
        end
        tick(1);
        c0_wr = 1'b0; c0_rd = 1'b0; c1_wr = 1'b0; c1_rd = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({c0_ready_a[0], c1_ready_a[0], p0_wr_a[0], p0_rd_a[0], c0_qv_a[0], c1_qv_a[0], c0_to_a[0], c1_to_a[0]} !== 8'b1100_0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want %b", {c0_ready_a[0], c1_ready_a[0], p0_wr_a[0], p0_rd_a[0], c0_qv_a[0], c1_qv_a[0], c0_to_a[0], c1_to_a[0]}, 8'b1100_0000); end
        n_cmp++; if ({p0_addr_a[0], p0_data_a[0], p0_be_a[0]} !== 43'd0) begin
            n_bad++; $display("FAIL reset_cmd: got %h want 0", {p0_addr_a[0], p0_data_a[0], p0_be_a[0]}); end
        n_cmp++; if ({c0_q_a[0], c1_q_a[0]} !== 64'd0) begin
            n_bad++; $display("FAIL reset_q: got %h want 0", {c0_q_a[0], c1_q_a[0]}); end
    endtask

    task automatic test_single_write();
        drive_req(0, 1'b1, 1'b0, 25'h0000123, 16'hBEEF, 2'b11);
        n_cmp++; if (c0_ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL wr_ready_low: got %b want 0", c0_ready_a[0]); end
        tick(1);
        n_cmp++; if ({p0_wr_a[0], p0_rd_a[0], p0_addr_a[0], p0_data_a[0], p0_be_a[0]} !== {1'b1, 1'b0, 25'h0000123, 16'hBEEF, 2'b11}) begin
            n_bad++; $display("FAIL wr_issue: got %b %b %h %h %b want 1 0 0000123 beef 11", p0_wr_a[0], p0_rd_a[0], p0_addr_a[0], p0_data_a[0], p0_be_a[0]); end
        tick(1);
        n_cmp++; if (p0_wr_a[0] !== 1'b0) begin n_bad++; $display("FAIL wr_pulse_width: got %b want 0", p0_wr_a[0]); end
        tick(3);
        n_cmp++; if (c0_ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL wr_ready_early: got %b want 0", c0_ready_a[0]); end
        tick(1);
        n_cmp++; if (c0_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL wr_ready_back: got %b want 1", c0_ready_a[0]); end
        n_cmp++; if ({n_iss[0] == 1, ord_wr[0][0], ord_addr[0][0], ord_data[0][0], ord_be[0][0]} !== {1'b1, 1'b1, 25'h0000123, 16'hBEEF, 2'b11}) begin
            n_bad++; $display("FAIL wr_log: got n=%0d wr=%b %h %h %b want n=1 wr=1 0000123 beef 11", n_iss[0], ord_wr[0][0], ord_addr[0][0], ord_data[0][0], ord_be[0][0]); end
    endtask

    task automatic test_read();
        model_q = 32'hCAFEF00D;
        drive_req(1, 1'b0, 1'b1, 25'h1000000, 16'h0000, 2'b11);
        n_cmp++; if (c1_ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL rd_ready_low: got %b want 0", c1_ready_a[0]); end
        tick(1);
        n_cmp++; if ({p0_wr_a[0], p0_rd_a[0], p0_addr_a[0]} !== {1'b0, 1'b1, 25'h1000000}) begin
            n_bad++; $display("FAIL rd_issue: got %b %b %h want 0 1 1000000", p0_wr_a[0], p0_rd_a[0], p0_addr_a[0]); end
        tick(4);
        n_cmp++; if (c1_qv_a[0] !== 1'b0) begin n_bad++; $display("FAIL rd_valid_early: got %b want 0", c1_qv_a[0]); end
        tick(1);
        n_cmp++; if ({c1_qv_a[0], c1_q_a[0], c1_ready_a[0], c0_qv_a[0]} !== {1'b1, 32'hCAFEF00D, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL rd_data: got v=%b q=%h rdy=%b c0v=%b want 1 cafef00d 1 0", c1_qv_a[0], c1_q_a[0], c1_ready_a[0], c0_qv_a[0]); end
        tick(1);
        n_cmp++; if ({c1_qv_a[0], c1_q_a[0]} !== {1'b0, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL rd_valid_pulse: got v=%b q=%h want 0 cafef00d", c1_qv_a[0], c1_q_a[0]); end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        model_q = 32'h1234_5678;
        drive_req(1, 1'b0, 1'b1, 25'h0ABCDEF, 16'h0000, 2'b11);
        tick(4);
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({c0_ready_a[0], c1_ready_a[0], p0_wr_a[0], p0_rd_a[0], c1_qv_a[0], c1_to_a[0]} !== 6'b110000) begin
            n_bad++; $display("FAIL midrst_flags: got %b want 110000", {c0_ready_a[0], c1_ready_a[0], p0_wr_a[0], p0_rd_a[0], c1_qv_a[0], c1_to_a[0]}); end
        n_cmp++; if ({p0_addr_a[0], c1_q_a[0]} !== 57'd0) begin
            n_bad++; $display("FAIL midrst_values: got addr=%h q=%h want 0 0", p0_addr_a[0], c1_q_a[0]); end
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            seen = seen | c1_qv_a[0] | c1_to_a[0];
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_pulse: got %b want 0", seen); end
        n_cmp++; if ({n_iss[0] == 0, c1_ready_a[0]} !== 2'b11) begin
            n_bad++; $display("FAIL midrst_dropped: got issues=%0d rdy=%b want 0 1", n_iss[0], c1_ready_a[0]); end
    endtask

    task automatic test_init_gating();
        do_reset();
        init_c = 1'b0;
        drive_req(0, 1'b1, 1'b0, 25'h0155555, 16'h1234, 2'b01);
        tick(5);
        n_cmp++; if ({p0_wr_a[0], n_iss[0] == 0, c0_ready_a[0]} !== 3'b010) begin
            n_bad++; $display("FAIL gate_hold: got wr=%b issues=%0d rdy=%b want 0 0 0", p0_wr_a[0], n_iss[0], c0_ready_a[0]); end
        init_c = 1'b1;
        tick(1);
        n_cmp++; if ({p0_wr_a[0], p0_addr_a[0], p0_be_a[0]} !== {1'b1, 25'h0155555, 2'b01}) begin
            n_bad++; $display("FAIL gate_issue: got %b %h %b want 1 0155555 01", p0_wr_a[0], p0_addr_a[0], p0_be_a[0]); end
        tick(5);
        n_cmp++; if (c0_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL gate_done: got %b want 1", c0_ready_a[0]); end
    endtask

    task automatic test_wr_rd_collision();
        do_reset();
        drive_req(0, 1'b1, 1'b1, 25'h0000AAA, 16'h5A5A, 2'b10);
        tick(1);
        n_cmp++; if ({p0_wr_a[0], p0_rd_a[0], p0_data_a[0]} !== {1'b1, 1'b0, 16'h5A5A}) begin
            n_bad++; $display("FAIL wrrd_issue: got %b %b %h want 1 0 5a5a", p0_wr_a[0], p0_rd_a[0], p0_data_a[0]); end
        tick(5);
        n_cmp++; if ({c0_ready_a[0], c0_qv_a[0]} !== 2'b10) begin
            n_bad++; $display("FAIL wrrd_done: got rdy=%b v=%b want 1 0", c0_ready_a[0], c0_qv_a[0]); end
        tick(6);
        n_cmp++; if (n_iss[0] !== 1) begin n_bad++; $display("FAIL wrrd_count: got %0d want 1", n_iss[0]); end
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        hang = 1'b1;
        drive_req(0, 1'b1, 1'b0, 25'h0000077, 16'h7777, 2'b11);
        seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick(1);
            seen = seen | c0_to_a[0] | c0_qv_a[0];
        end
        n_cmp++; if ({seen, c0_ready_a[0]} !== 2'b00) begin
            n_bad++; $display("FAIL tmo_early: got pulse=%b rdy=%b want 0 0", seen, c0_ready_a[0]); end
        tick(1);
        n_cmp++; if ({c0_to_a[0], c0_ready_a[0], c0_qv_a[0], c1_to_a[0]} !== 4'b1100) begin
            n_bad++; $display("FAIL tmo_pulse: got to=%b rdy=%b v=%b c1to=%b want 1 1 0 0", c0_to_a[0], c0_ready_a[0], c0_qv_a[0], c1_to_a[0]); end
        tick(1);
        n_cmp++; if ({c0_to_a[0], c0_qv_a[0]} !== 2'b00) begin
            n_bad++; $display("FAIL tmo_width: got to=%b v=%b want 0 0", c0_to_a[0], c0_qv_a[0]); end
        hang = 1'b0;
    endtask

    task automatic test_contention();
        logic [24:0] exp_rr [4];
        logic [24:0] exp_fp [4];
        exp_rr[0] = 25'h0000C00; exp_rr[1] = 25'h0000C11; exp_rr[2] = 25'h0000C00; exp_rr[3] = 25'h0000C11;
        exp_fp[0] = 25'h0000C00; exp_fp[1] = 25'h0000C00; exp_fp[2] = 25'h0000C00; exp_fp[3] = 25'h0000C00;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            init_c = 1'b0;
            c0_addr = 25'h0000C00; c0_data = 16'h0C0C; c0_be = 2'b11; c0_wr = 1'b1;
            c1_addr = 25'h0000C11; c1_data = 16'h1C1C; c1_be = 2'b11; c1_wr = 1'b1;
            tick(1);
            c0_wr = 1'b0; c1_wr = 1'b0;
            init_c = 1'b1;
            tick(6);
        end
        init_c = 1'b0;
        n_cmp++; if ({n_iss[0] == 4, n_iss[1] == 4} !== 2'b11) begin
            n_bad++; $display("FAIL cont_count: got rr=%0d fp=%0d want 4 4", n_iss[0], n_iss[1]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ord_addr[0][k] !== exp_rr[k]) begin
                n_bad++; $display("FAIL cont_rr_order[%0d]: got %h want %h", k, ord_addr[0][k], exp_rr[k]); end
            n_cmp++; if (ord_addr[1][k] !== exp_fp[k]) begin
                n_bad++; $display("FAIL cont_fp_order[%0d]: got %h want %h", k, ord_addr[1][k], exp_fp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_reset_mid_op();
        test_init_gating();
        test_wr_rd_collision();
        test_timeout();
        test_contention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
